// File: rtl/kbd_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, reads rows back,
// debounces whole-keypad scans and hands one key code per press to the CPU.
module kbd_scan #(
    parameter int CLK_DIV  = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       KEY_DOWN,
    output logic       OVERRUN
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE);

    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_KEY   = 2'd1;
    localparam logic [1:0] CLS_MULTI = 2'd2;

    // Scan result / debounce state encoding: {is_key, code}; all-zero means NONE.
    localparam logic [4:0] RES_NONE = 5'b0_0000;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    col_idx;
    logic [1:0]    col_next;
    logic [11:0]   samp;
    logic [15:0]   scan_bits;
    logic [4:0]    ones;
    logic [3:0]    hit_code;
    logic [1:0]    cls;
    logic          scan_done;
    logic [4:0]    scan_res;
    logic [4:0]    cand;
    logic [4:0]    cand_nxt;
    logic [4:0]    stable;
    logic [4:0]    stable_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          key_event;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    assign tick     = (presc == PRESC_LAST);
    assign col_next = col_idx + 2'd1;

    // Column 3 is never stored: its rows are used live on the completing tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc   <= '0;
            col_idx <= 2'd0;
            COL     <= 4'b1110;
            samp    <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                case (col_idx)
                    2'd0:    samp[3:0]  <= ~row_sync;
                    2'd1:    samp[7:4]  <= ~row_sync;
                    2'd2:    samp[11:8] <= ~row_sync;
                    default: ;
                endcase
                col_idx <= col_next;
                COL     <= ~(4'b0001 << col_next);
            end
        end
    end

    always_comb begin
        scan_bits = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                scan_bits[r*4 + c] = samp[c*4 + r];
            end
            scan_bits[r*4 + 3] = ~row_sync[r];
        end
    end

    always_comb begin
        ones     = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_bits[i]) begin
                ones     = ones + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    always_comb begin
        cls = CLS_MULTI;
        if (ones == 5'd0) begin
            cls = CLS_NONE;
        end else if (ones == 5'd1) begin
            cls = CLS_KEY;
        end
    end

    assign scan_done = tick && (col_idx == 2'd3);
    assign scan_res  = (cls == CLS_KEY) ? {1'b1, hit_code} : RES_NONE;

    // Multi-key scans leave the debouncer untouched so rollover cannot fake a release.
    always_comb begin
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        if (scan_done && (cls != CLS_MULTI)) begin
            if (scan_res == cand) begin
                if (cnt != DEB_MAX) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                cand_nxt = scan_res;
                cnt_nxt  = CW'(1);
            end
            if ((cnt_nxt == DEB_MAX) && (cand_nxt != stable)) begin
                stable_nxt = cand_nxt;
            end
        end
    end

    assign key_event = stable_nxt[4] && (stable_nxt != stable);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cand   <= RES_NONE;
            cnt    <= '0;
            stable <= RES_NONE;
        end else begin
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
        end
    end

    // A new key outranks a simultaneous ack, so the CPU never loses a fresh press.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            KEY_CODE  <= 4'd0;
            KEY_VALID <= 1'b0;
            KEY_DOWN  <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            KEY_DOWN <= stable_nxt[4];
            if (key_event) begin
                KEY_CODE  <= stable_nxt[3:0];
                KEY_VALID <= 1'b1;
                if (KEY_ACK) begin
                    OVERRUN <= 1'b0;
                end else if (KEY_VALID) begin
                    OVERRUN <= 1'b1;
                end
            end else if (KEY_ACK) begin
                KEY_VALID <= 1'b0;
                OVERRUN   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_scan.sv
// Directed bench for kbd_scan with a combinational keypad model on COL/ROW.
module tb_kbd_scan;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_ACK;
    logic        KEY_DOWN;
    logic        OVERRUN;
    logic [15:0] keys;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 CLK = ~CLK;

    // Held key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        ROW = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !COL[c]) ROW[r] = 1'b0;
            end
        end
    end

    kbd_scan #(.CLK_DIV(4), .DEBOUNCE(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .COL      (COL),
        .ROW      (ROW),
        .KEY_CODE (KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .KEY_ACK  (KEY_ACK),
        .KEY_DOWN (KEY_DOWN),
        .OVERRUN  (OVERRUN)
    );

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ack_pulse();
        KEY_ACK = 1'b1;
        step(1);
        KEY_ACK = 1'b0;
    endtask

    // sel 0: KEY_VALID high, sel 1: KEY_DOWN low, sel 2: KEY_CODE equals code
    task automatic wait_for(input int sel, input logic [3:0] code, input int budget,
                            output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            step(1);
            cycles++;
            case (sel)
                0:       ok = (KEY_VALID === 1'b1);
                1:       ok = (KEY_DOWN === 1'b0);
                default: ok = (KEY_CODE === code);
            endcase
        end
    endtask

    task automatic test_reset();
        KEY_ACK = 1'b0;
        keys    = '0;
        RESET   = 1'b1;
        step(2);
        n_checks++; if (COL !== 4'b1110) $display("[TB] FAIL reset_col: got %b expected 1110", COL); else n_pass++;
        n_checks++; if (KEY_CODE !== 4'd0) $display("[TB] FAIL reset_code: got %0d expected 0", KEY_CODE); else n_pass++;
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_DOWN !== 1'b0) $display("[TB] FAIL reset_down: got %b expected 0", KEY_DOWN); else n_pass++;
        n_checks++; if (OVERRUN !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", OVERRUN); else n_pass++;
        RESET = 1'b0;
        keys  = 16'h0001 << 5;
        step(38);
        RESET = 1'b1;
        step(3);
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL reset_mid_valid: got %b expected 0", KEY_VALID); else n_pass++;
        RESET = 1'b0;
        step(47);
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL reset_no_early_valid: got %b expected 0", KEY_VALID); else n_pass++;
        step(1);
        n_checks++; if (KEY_VALID !== 1'b1) $display("[TB] FAIL reset_fresh_valid: got %b expected 1", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_CODE !== 4'd5) $display("[TB] FAIL reset_fresh_code: got %0d expected 5", KEY_CODE); else n_pass++;
        ack_pulse();
        keys = '0;
        step(80);
    endtask

    task automatic test_press();
        int cyc;
        bit ok;
        keys = 16'h0001 << 9;
        wait_for(0, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok || cyc > 67) $display("[TB] FAIL press_latency: got %0d cycles (seen=%0d) expected <= 67", cyc, ok); else n_pass++;
        n_checks++; if (KEY_CODE !== 4'd9) $display("[TB] FAIL press_code: got %0d expected 9", KEY_CODE); else n_pass++;
        n_checks++; if (KEY_DOWN !== 1'b1) $display("[TB] FAIL press_down: got %b expected 1", KEY_DOWN); else n_pass++;
        step(320);
        n_checks++; if (OVERRUN !== 1'b0) $display("[TB] FAIL press_hold_no_repeat: got overrun %b expected 0", OVERRUN); else n_pass++;
        n_checks++; if (KEY_VALID !== 1'b1) $display("[TB] FAIL press_hold_valid: got %b expected 1", KEY_VALID); else n_pass++;
        ack_pulse();
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL press_ack_valid: got %b expected 0", KEY_VALID); else n_pass++;
        keys = '0;
        wait_for(1, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok) $display("[TB] FAIL press_release_down: got %b expected 0", KEY_DOWN); else n_pass++;
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL press_release_valid: got %b expected 0", KEY_VALID); else n_pass++;
    endtask

    task automatic test_bounce();
        int cyc;
        bit ok;
        keys = '0;
        for (int i = 0; i < 12; i++) begin
            keys[3] = ~keys[3];
            step(5);
        end
        keys = 16'h0001 << 3;
        step(96);
        n_checks++; if (KEY_VALID !== 1'b1) $display("[TB] FAIL bounce_valid: got %b expected 1", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_CODE !== 4'd3) $display("[TB] FAIL bounce_code: got %0d expected 3", KEY_CODE); else n_pass++;
        n_checks++; if (OVERRUN !== 1'b0) $display("[TB] FAIL bounce_single_event: got overrun %b expected 0", OVERRUN); else n_pass++;
        ack_pulse();
        keys = '0;
        wait_for(1, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok) $display("[TB] FAIL bounce_release_down: got %b expected 0", KEY_DOWN); else n_pass++;
        keys = 16'h0001 << 3;
        step(16);
        keys = '0;
        step(96);
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL glitch_valid: got %b expected 0", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_DOWN !== 1'b0) $display("[TB] FAIL glitch_down: got %b expected 0", KEY_DOWN); else n_pass++;
    endtask

    task automatic test_overrun();
        int cyc;
        bit ok;
        keys = 16'h0001;
        wait_for(0, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok || KEY_CODE !== 4'd0) $display("[TB] FAIL ovr_first_event: got valid %b code %0d expected 1 / 0", KEY_VALID, KEY_CODE); else n_pass++;
        n_checks++; if (OVERRUN !== 1'b0) $display("[TB] FAIL ovr_first_overrun: got %b expected 0", OVERRUN); else n_pass++;
        keys = '0;
        wait_for(1, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok) $display("[TB] FAIL ovr_release_down: got %b expected 0", KEY_DOWN); else n_pass++;
        keys = 16'h0001 << 15;
        wait_for(2, 4'd15, 70, cyc, ok);
        n_checks++; if (!ok) $display("[TB] FAIL ovr_code: got %0d expected 15", KEY_CODE); else n_pass++;
        n_checks++; if (KEY_VALID !== 1'b1) $display("[TB] FAIL ovr_valid: got %b expected 1", KEY_VALID); else n_pass++;
        n_checks++; if (OVERRUN !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", OVERRUN); else n_pass++;
        ack_pulse();
        n_checks++; if (KEY_VALID !== 1'b0 || OVERRUN !== 1'b0) $display("[TB] FAIL ovr_ack_clear: got valid %b overrun %b expected 0 / 0", KEY_VALID, OVERRUN); else n_pass++;
        keys = '0;
        wait_for(1, 4'd0, 70, cyc, ok);
    endtask

    // Restarting from reset fixes the scan phase, so the event edge is known exactly.
    task automatic test_simultaneous();
        keys  = 16'h0001;
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        step(48);
        n_checks++; if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd0) $display("[TB] FAIL simul_pending: got valid %b code %0d expected 1 / 0", KEY_VALID, KEY_CODE); else n_pass++;
        step(16);
        keys = 16'h0001 << 6;
        step(47);
        n_checks++; if (KEY_CODE !== 4'd0) $display("[TB] FAIL simul_not_early: got code %0d expected 0", KEY_CODE); else n_pass++;
        KEY_ACK = 1'b1;
        step(1);
        KEY_ACK = 1'b0;
        n_checks++; if (KEY_VALID !== 1'b1) $display("[TB] FAIL simul_valid: got %b expected 1", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_CODE !== 4'd6) $display("[TB] FAIL simul_code: got %0d expected 6", KEY_CODE); else n_pass++;
        n_checks++; if (OVERRUN !== 1'b0) $display("[TB] FAIL simul_overrun: got %b expected 0", OVERRUN); else n_pass++;
        ack_pulse();
        keys = '0;
        step(80);
    endtask

    task automatic test_multi();
        int cyc;
        bit ok;
        keys = 16'h0001 << 1;
        wait_for(0, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok || KEY_CODE !== 4'd1) $display("[TB] FAIL multi_first: got valid %b code %0d expected 1 / 1", KEY_VALID, KEY_CODE); else n_pass++;
        ack_pulse();
        keys = (16'h0001 << 1) | (16'h0001 << 10);
        step(96);
        n_checks++; if (KEY_VALID !== 1'b0) $display("[TB] FAIL multi_no_event: got %b expected 0", KEY_VALID); else n_pass++;
        n_checks++; if (KEY_DOWN !== 1'b1) $display("[TB] FAIL multi_down: got %b expected 1", KEY_DOWN); else n_pass++;
        ack_pulse();
        n_checks++; if (KEY_VALID !== 1'b0 || KEY_CODE !== 4'd1 || OVERRUN !== 1'b0) $display("[TB] FAIL idle_ack: got valid %b code %0d overrun %b expected 0 / 1 / 0", KEY_VALID, KEY_CODE, OVERRUN); else n_pass++;
        keys = 16'h0001 << 10;
        wait_for(0, 4'd0, 70, cyc, ok);
        n_checks++; if (!ok || KEY_CODE !== 4'd10) $display("[TB] FAIL multi_rollover: got valid %b code %0d expected 1 / 10", KEY_VALID, KEY_CODE); else n_pass++;
        ack_pulse();
        keys = '0;
        step(80);
    endtask

    initial begin
        KEY_ACK = 1'b0;
        keys    = '0;
        RESET   = 1'b1;
        test_reset();
        test_press();
        test_bounce();
        test_overrun();
        test_simultaneous();
        test_multi();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
